// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI responder: oversampled MSB-first receive with valid/ready output and miso reply
module spi_slave_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              overrun,
   output logic              frame_err
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] FULL = CW'(DATA_W);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t                 state;
   logic [CW-1:0]          bit_cnt;
   logic [DATA_W-1:0]      rx_shift;
   logic [DATA_W-1:0]      tx_shift;
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         cs_d      <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = ~sclk_d & sclk_s;
   assign sclk_fall = sclk_d & ~sclk_s;
   assign cs_rise   = ~cs_d & cs_s;
   assign cs_fall   = cs_d & ~cs_s;

   assign miso = ~cs_s & tx_shift[DATA_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state    <= SHIFT;
                  bit_cnt  <= '0;
                  tx_shift <= tx_data;
               end
            end
            SHIFT: begin
               if (bit_cnt == FULL) begin
                  // word completed on the previous cycle; a same-cycle handshake frees the slot
                  state <= cs_rise ? IDLE : HOLD;
                  if (!rx_valid || rx_ready) begin
                     rx_data  <= rx_shift;
                     rx_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else if (cs_rise) begin
                  state     <= IDLE;
                  frame_err <= (bit_cnt != '0);
                  bit_cnt   <= '0;
               end else begin
                  if (sclk_fall) begin
                     rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                     bit_cnt  <= bit_cnt + 1'b1;
                  end
                  // first rise presents the preloaded MSB; later rises advance
                  if (sclk_rise && bit_cnt != '0)
                     tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
               end
            end
            HOLD: begin
               if (cs_rise)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
